// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 key events and MiSTer joysticks into registered per-player controls
// with rotation, opposing-direction cleaning and stretched coin pulses.
module arcade_input_mapper #(
  parameter int PLAYERS   = 2,
  parameter int BTNS      = 2,
  parameter int COIN_HOLD = 200000,
  parameter int JOY_SHARE = 0,
  parameter int SOCD_CLR  = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [10:0]       ps2_key,
  input  logic [15:0]       joystick_0,
  input  logic [15:0]       joystick_1,
  input  logic [1:0]        rotate,
  output logic [3+BTNS:0]   p1_ctl,
  output logic [3+BTNS:0]   p2_ctl,
  output logic [PLAYERS-1:0] start,
  output logic [PLAYERS-1:0] coin
);
  localparam int W = 4 + BTNS;
  localparam logic [23:0] HOLD_M1 = 24'(COIN_HOLD - 1);
  localparam logic [3:0] BMASK = 4'((1 << BTNS) - 1);

  // Key state per player, 10 bits each: {coin, start, btn[3:0], U, D, L, R}; player 2 in [19:10].
  function automatic logic [19:0] decode(input logic ext, input logic [7:0] code);
    logic [19:0] h;
    h = '0;
    case (code)
      8'h74: h[0] = 1'b1;
      8'h6B: h[1] = 1'b1;
      8'h72: h[2] = 1'b1;
      8'h75: h[3] = 1'b1;
      default: ;
    endcase
    if (!ext)
      case (code)
        8'h14: h[4]  = 1'b1;
        8'h11: h[5]  = 1'b1;
        8'h29: h[6]  = 1'b1;
        8'h12: h[7]  = 1'b1;
        8'h16: h[8]  = 1'b1;
        8'h2E: h[9]  = 1'b1;
        8'h34: h[10] = 1'b1;
        8'h23: h[11] = 1'b1;
        8'h2B: h[12] = 1'b1;
        8'h2D: h[13] = 1'b1;
        8'h1C: h[14] = 1'b1;
        8'h1B: h[15] = 1'b1;
        8'h15: h[16] = 1'b1;
        8'h1D: h[17] = 1'b1;
        8'h1E: h[18] = 1'b1;
        8'h36: h[19] = 1'b1;
        default: ;
      endcase
    return h;
  endfunction

  logic armed_q, armed_d, tog_q, tog_d, ev;
  logic [19:0] key_q, key_d, hit;
  logic [1:0][15:0] joy;
  logic [1:0][9:0] raw;
  logic [9:0] k;
  logic [3:0] d, r;
  logic [1:0][W-1:0] ctl_q, ctl_d;
  logic [1:0] start_q, start_d, coin_q, coin_d, cprev_q, cprev_d;
  logic [1:0][23:0] cnt_q, cnt_d;

  always_comb begin
    hit = decode(ps2_key[8], ps2_key[7:0]);
    armed_d = 1'b1;
    tog_d = ps2_key[10];
    ev = armed_q && (ps2_key[10] != tog_q);
    key_d = ev ? (key_q & ~hit) | (hit & {20{ps2_key[9]}}) : key_q;
    joy[0] = JOY_SHARE != 0 ? joystick_0 | joystick_1 : joystick_0;
    joy[1] = JOY_SHARE != 0 ? 16'h0 : joystick_1;
    raw = '0;
    k = '0;
    d = '0;
    r = '0;
    ctl_d = '0;
    start_d = '0;
    coin_d = '0;
    cprev_d = '0;
    cnt_d = '0;
    for (int p = 0; p < 2; p++) begin
      k = key_q[p*10 +: 10];
      raw[p] = {k[9] | joy[p][5+BTNS], k[8] | joy[p][4+BTNS], (k[7:4] | joy[p][7:4]) & BMASK, k[3:0] | joy[p][3:0]};
      d = raw[p][3:0];
      r = rotate == 2'd1 ? {d[1], d[0], d[2], d[3]} :
          rotate == 2'd2 ? {d[0], d[1], d[3], d[2]} :
          rotate == 2'd3 ? {d[2], d[3], d[0], d[1]} : d;
      r[3:2] = (SOCD_CLR != 0 && &r[3:2]) ? 2'b00 : r[3:2];
      r[1:0] = (SOCD_CLR != 0 && &r[1:0]) ? 2'b00 : r[1:0];
      ctl_d[p] = p < PLAYERS ? {raw[p][4 +: BTNS], r} : '0;
      start_d[p] = p < PLAYERS && raw[p][8];
      coin_d[p] = p < PLAYERS && (raw[p][9] || cnt_q[p] != 24'd0);
      cnt_d[p] = (raw[p][9] && !cprev_q[p]) ? HOLD_M1 : (cnt_q[p] != 24'd0 ? cnt_q[p] - 24'd1 : 24'd0);
      cprev_d[p] = raw[p][9];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      armed_q <= 1'b0;
      tog_q   <= 1'b0;
      key_q   <= '0;
      ctl_q   <= '0;
      start_q <= '0;
      coin_q  <= '0;
      cprev_q <= '0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      tog_q   <= tog_d;
      key_q   <= key_d;
      ctl_q   <= ctl_d;
      start_q <= start_d;
      coin_q  <= coin_d;
      cprev_q <= cprev_d;
      cnt_q   <= cnt_d;
    end

  assign p1_ctl = ctl_q[0];
  assign p2_ctl = ctl_q[1];
  assign start  = start_q[PLAYERS-1:0];
  assign coin   = coin_q[PLAYERS-1:0];
endmodule
